cmp_arbiter: RTL and testbench

CMP_ARBITER -- requirements
Module: cmp_arbiter

---
 rtl/cmp_arbiter.sv | 121 ++++++++++++
 tb/tb_cmp_arbiter.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/cmp_arbiter.sv
// Four-requester round-robin arbiter feeding one shared unsigned comparator (IDLE -> CMP -> DONE).
// Defining CMP_ARB_FIXED_PRIO_EN swaps round-robin for fixed priority (requester 0 highest).
module cmp_arbiter #(
  parameter int WIDTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [3:0]         req,
  input  logic [4*WIDTH-1:0] a_in,
  input  logic [4*WIDTH-1:0] b_in,
  output logic [3:0]         gnt,
  output logic [3:0]         rsp_valid,
  output logic               a_gt_b,
  output logic               a_eq_b,
  output logic               a_ls_b,
  output logic               busy
);

  typedef enum logic [1:0] {IDLE, CMP, DONE} state_t;

  state_t           state, state_nxt;
  logic             grant_en, cmp_en;
  logic [1:0]       win, win_lat;
  logic [WIDTH-1:0] a_sel, b_sel, a_lat, b_lat;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    grant_en  = 1'b0;
    cmp_en    = 1'b0;
    case (state)
      IDLE: if (|req) begin
        state_nxt = CMP;
        grant_en  = 1'b1;
      end
      CMP: begin
        state_nxt = DONE;
        cmp_en    = 1'b1;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

`ifdef CMP_ARB_FIXED_PRIO_EN
  always_comb begin
    win = '0;
    for (int k = 3; k >= 0; k--) begin
      if (req[k]) win = 2'(k);
    end
  end
`else
  logic [1:0] ptr, rr_idx;
  logic       rr_found;

  // Scan starts at ptr and wraps modulo 4 through the 2-bit add.
  always_comb begin
    win      = '0;
    rr_idx   = '0;
    rr_found = 1'b0;
    for (int k = 0; k < 4; k++) begin
      rr_idx = ptr + 2'(k);
      if (!rr_found && req[rr_idx]) begin
        win      = rr_idx;
        rr_found = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst)         ptr <= '0;
    else if (cmp_en) ptr <= win_lat + 2'd1;
  end
`endif

  always_comb begin
    a_sel = '0;
    b_sel = '0;
    for (int k = 0; k < 4; k++) begin
      if (win == 2'(k)) begin
        a_sel = a_in[k*WIDTH +: WIDTH];
        b_sel = b_in[k*WIDTH +: WIDTH];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      gnt       <= '0;
      rsp_valid <= '0;
      a_gt_b    <= 1'b0;
      a_eq_b    <= 1'b0;
      a_ls_b    <= 1'b0;
      a_lat     <= '0;
      b_lat     <= '0;
      win_lat   <= '0;
    end else begin
      gnt       <= '0;
      rsp_valid <= '0;
      if (grant_en) begin
        gnt     <= 4'b0001 << win;
        a_lat   <= a_sel;
        b_lat   <= b_sel;
        win_lat <= win;
      end
      if (cmp_en) begin
        rsp_valid <= 4'b0001 << win_lat;
        a_gt_b    <= (a_lat >  b_lat);
        a_eq_b    <= (a_lat == b_lat);
        a_ls_b    <= (a_lat <  b_lat);
      end
    end
  end

  assign busy = (state != IDLE);

endmodule

// File: tb/tb_cmp_arbiter.sv
// Randomised and directed bench for cmp_arbiter against a per-transaction timeline model.
module tb_cmp_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [7:0] a_in, b_in;
  logic [3:0] gnt, rsp_valid;
  logic       a_gt_b, a_eq_b, a_ls_b, busy;

  int checks = 0;
  int errors = 0;

  cmp_arbiter #(.WIDTH(2)) dut (
    .clk(clk), .rst(rst), .req(req), .a_in(a_in), .b_in(b_in),
    .gnt(gnt), .rsp_valid(rsp_valid),
    .a_gt_b(a_gt_b), .a_eq_b(a_eq_b), .a_ls_b(a_ls_b), .busy(busy)
  );

  always #5 clk = ~clk;

  // Reference: a grant opens a 2-cycle service window; response lands on its second edge.
  int         left;
  int         mptr;
  int         cur_w, cur_a, cur_b;
  logic [3:0] e_gnt, e_rsp;
  logic [2:0] e_flags;
  logic       e_busy;
  logic [3:0] gq[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int p);
    int res;
    int j;
    res = -1;
`ifdef CMP_ARB_FIXED_PRIO_EN
    for (int k = 3; k >= 0; k--) if (r[k]) res = k;
`else
    for (int k = 0; k < 4; k++) begin
      j = (p + k) % 4;
      if (res < 0 && r[j]) res = j;
    end
`endif
    return res;
  endfunction

  function automatic logic [7:0] put(input int i, input logic [1:0] v);
    logic [7:0] t;
    t = {6'b0, v};
    return t << (2 * i);
  endfunction

  task automatic model_edge();
    e_gnt = '0;
    e_rsp = '0;
    if (rst) begin
      left = 0; mptr = 0; e_flags = '0;
    end else if (left == 0) begin
      if (req != 0) begin
        cur_w = pick(req, mptr);
        cur_a = (a_in >> (2 * cur_w)) & 3;
        cur_b = (b_in >> (2 * cur_w)) & 3;
        e_gnt = 4'(1 << cur_w);
        left  = 2;
      end
    end else if (left == 2) begin
      e_rsp   = 4'(1 << cur_w);
      e_flags = (cur_a > cur_b) ? 3'b100 : (cur_a == cur_b) ? 3'b010 : 3'b001;
`ifndef CMP_ARB_FIXED_PRIO_EN
      mptr = (cur_w + 1) % 4;
`endif
      left = 1;
    end else begin
      left = 0;
    end
    e_busy = (left != 0);
  endtask

  task automatic step(input logic [3:0] r, input logic [7:0] a, input logic [7:0] b, input logic rs);
    req = r; a_in = a; b_in = b; rst = rs;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("gnt", gnt, e_gnt);
    chk("rsp_valid", rsp_valid, e_rsp);
    chk("flags", {a_gt_b, a_eq_b, a_ls_b}, e_flags);
    chk("busy", busy, e_busy);
    chk("gnt_onehot", ($countones(gnt) <= 1), 1);
    chk("rsp_onehot", ($countones(rsp_valid) <= 1), 1);
    if (gnt != 0) gq.push_back(gnt);
  endtask

  initial begin
    logic [3:0] exp_rr [5];
    logic [3:0] rr;
    logic [7:0] ra, rb;
    int saw8;

    left = 0; mptr = 0; e_flags = '0; e_gnt = '0; e_rsp = '0; e_busy = 0;
    step(4'b0000, 8'h00, 8'h00, 1'b1);
    step(4'b1111, 8'hFF, 8'h00, 1'b1);
    chk("reset_outs", {gnt, rsp_valid, a_gt_b, a_eq_b, a_ls_b, busy}, 0);

    // single request, a > b
    step(4'b0001, put(0, 2'b11), put(0, 2'b10), 1'b0);
    chk("single_gnt", gnt, 4'b0001);
    step(4'b0000, 8'h00, 8'h00, 1'b0);
    chk("single_rsp", rsp_valid, 4'b0001);
    chk("single_gt", {a_gt_b, a_eq_b, a_ls_b}, 3'b100);
    step(4'b0000, 8'h00, 8'h00, 1'b0);

    // equal, then less
    step(4'b0100, put(2, 2'b01), put(2, 2'b01), 1'b0);
    step(4'b0000, 8'h00, 8'h00, 1'b0);
    chk("eq_rsp", rsp_valid, 4'b0100);
    chk("eq_flags", {a_gt_b, a_eq_b, a_ls_b}, 3'b010);
    step(4'b0000, 8'h00, 8'h00, 1'b0);
    step(4'b0100, put(2, 2'b10), put(2, 2'b11), 1'b0);
    step(4'b0000, 8'h00, 8'h00, 1'b0);
    chk("ls_flags", {a_gt_b, a_eq_b, a_ls_b}, 3'b001);
    step(4'b0000, 8'h00, 8'h00, 1'b0);

    // service order with all four requesting from ptr 0
    step(4'b0000, 8'h00, 8'h00, 1'b1);
    gq.delete();
    for (int i = 0; i < 15; i++) step(4'b1111, 8'h1B, 8'hE4, 1'b0);
`ifdef CMP_ARB_FIXED_PRIO_EN
    exp_rr = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0001};
`else
    exp_rr = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
`endif
    chk("rr_count", gq.size(), 5);
    for (int i = 0; i < 5 && i < gq.size(); i++) chk("rr_order", gq[i], exp_rr[i]);

    // reset while in CMP aborts the compare and leaves ptr at 0
    step(4'b0000, 8'h00, 8'h00, 1'b1);
    step(4'b0010, put(1, 2'b11), put(1, 2'b00), 1'b0);
    chk("abort_gnt", gnt, 4'b0010);
    step(4'b0000, 8'h00, 8'h00, 1'b1);
    chk("abort_rsp", rsp_valid, 4'b0000);
    chk("abort_flags", {a_gt_b, a_eq_b, a_ls_b}, 3'b000);
    chk("abort_busy", busy, 1'b0);
    step(4'b1111, 8'h00, 8'h00, 1'b0);
    chk("abort_ptr", gnt, 4'b0001);
    step(4'b0000, 8'h00, 8'h00, 1'b0);
    step(4'b0000, 8'h00, 8'h00, 1'b0);

    // withdrawal while busy, then request raised during DONE
    gq.delete();
    step(4'b0001, 8'h00, 8'h00, 1'b0);
    step(4'b1000, 8'h00, 8'h00, 1'b0);
    step(4'b0001, 8'h00, 8'h00, 1'b0);
    chk("done_idle", busy, 1'b0);
    step(4'b0001, 8'h00, 8'h00, 1'b0);
    chk("late_gnt", gnt, 4'b0001);
    step(4'b0000, 8'h00, 8'h00, 1'b0);
    step(4'b0000, 8'h00, 8'h00, 1'b0);
    step(4'b0000, 8'h00, 8'h00, 1'b0);
    saw8 = 0;
    foreach (gq[i]) if (gq[i] == 4'b1000) saw8++;
    chk("withdrawn_gnt", saw8, 0);
    chk("withdraw_grants", gq.size(), 2);

    // random traffic with occasional resets
    for (int i = 0; i < 400; i++) begin
      rr = ($urandom_range(0, 1) == 0) ? 4'b0000 : 4'($urandom_range(0, 15));
      ra = 8'($urandom);
      rb = 8'($urandom);
      step(rr, ra, rb, ($urandom_range(0, 49) == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
